muldiv_unit: RTL
================

# muldiv_unit

- Parametrised iterative multiply/divide unit implementing the RV32M operation set at any operand width.
- Sits beside the single-cycle ALU in the execute stage. The core stalls on `busy` and takes the result on `done`.
- Runs one shift-add (multiply) or restoring-subtract (divide) step per clock. Divide-by-zero and signed overflow take a 1-cycle fast path.
- Outputs a registered result and a zero flag with the same meaning as the ALU's `zero_flag`.

## Interface

Parameters:
- `WIDTH`, 32 — operand and result width (≥ 4).
- `CNT_W`, $clog2(WIDTH)+1 — width of the iteration counter.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — request; sampled only in IDLE or DONE.
- `op` input 3 — RV32M funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `in1` input WIDTH — rs1 operand (multiplicand / dividend).
- `in2` input WIDTH — rs2 operand (multiplier / divisor).
- `busy` output 1 — operation in progress; high in CALC.
- `done` output 1 — one-cycle pulse; `result` is valid.
- `result` output WIDTH — registered result.
- `zero_flag` output 1 — (result == 0), registered with `result`.

## Operation

States: IDLE, CALC, DONE.

IDLE/DONE with `start`=1:
- Latch `op` and the operand magnitudes. Signed operands are negated if negative; MULHSU treats only `in1` as signed.
- Latch the required result sign:
  - MUL*: sign(in1) XOR sign(in2).
  - DIV: sign(in1) XOR sign(in2).
  - REM: sign(in1).
- Load the counter with WIDTH and go to CALC.

Fast path, decided at start; goes CALC for exactly one cycle, then DONE:
- `in2`==0 with DIV/DIVU: result = all ones.
- `in2`==0 with REM/REMU: result = `in1`.
- DIV with `in1` = 1<<(WIDTH-1) and `in2` = all ones: result = `in1`.
- REM with the same operands: result = 0.

CALC, normal path:
- One iteration per cycle; counter decrements. When it reaches 0, go to DONE.
- Multiply: 2·WIDTH-bit accumulator, shift-add on the multiplier LSB.
  - MUL returns the low WIDTH bits of the sign-corrected product.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide: restoring division with a WIDTH+1-bit partial remainder. Quotient and remainder are sign-corrected after the last step.

Leaving CALC (the same edge that enters DONE):
- Register `result` and `zero_flag`.
- `done` is 1 for the DONE cycle only.

DONE:
- Returns to IDLE on the next edge unless `start`=1. If `start`=1, a new operation is accepted (back-to-back).

Other rules:
- `start` in CALC is ignored; no queueing.
- `op`, `in1` and `in2` are don't-care after the accepting edge.
- `result` and `zero_flag` hold their value until the next completion.

Reset (`rst_n`=0, any state, takes effect immediately):
- state = IDLE, `busy`=0, `done`=0, `result`=0, `zero_flag`=0, counter = 0.
- An in-flight operation is discarded and never produces `done`.

## Timing

- Start accepted at edge E0: `busy`=1 from E0.
- Normal path: `done`=1 and `result` valid after edge E_WIDTH (E32 at default), with `busy`=0 in that same cycle.
- Fast path: `done` after E1.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts from DONE.
- `busy` and `done` are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

All scenarios use WIDTH=32 unless stated.

1. MUL, in1=23, in2=42, start at E0 → `busy` E0..E31, `done` after E32, result=966, `zero_flag`=0.
2. MULH with 0xFFFFFFFF×0xFFFFFFFF → result 0, `zero_flag`=1. MULHU with the same operands → result 0xFFFFFFFE. MULHSU with 0xFFFFFFFF×2 → result 0xFFFFFFFF.
3. DIV −42/23 → result 0xFFFFFFFF. REM −42/23 → result 0xFFFFFFED. DIVU 42/23 → result 1. REMU 42/23 → result 19.
4. Fast path, each with `done` after E1:
   - DIV 42/0 → 0xFFFFFFFF.
   - REMU 42/0 → 42.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
   - REM with the same operands → 0 with `zero_flag`=1.
5. Start MUL 23×42. Pulse `start` with DIV at E10 → ignored; result 966 after E32. Raise `start` in the DONE cycle → second operation accepted, `busy` the next cycle.
6. Assert `rst_n`=0 at cycle 15 of a DIV → outputs 0 immediately and no `done`. Repeat with WIDTH=8: MULHU 0xFF×0xFF → result 0xFE after E8.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit, parametrised operand width.
//            One shift-add (multiply) or restoring-subtract (divide) step per
//            clock. Divide-by-zero and signed overflow finish after a single
//            CALC cycle.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            start_i            - request, sampled in IDLE or DONE only
//            op_i[2:0]          - RV32M funct3 (MUL..REMU)
//            in1_i, in2_i       - rs1 / rs2 operands
//            busy_o             - high while an operation is in CALC
//            done_o             - one-cycle pulse, result_o valid
//            result_o           - registered result
//            zero_flag_o        - registered (result_o == 0)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_flag_o
);

  localparam logic [WIDTH-1:0] c_ones = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               fast_q, fast_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply: {high, low} product with the multiplier in the low half.
  // Divide  : {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  // ---------------------------------------------------------------- operand decode
  logic             w_s1_signed, w_s2_signed, w_neg1, w_neg2, w_neg;
  logic [WIDTH-1:0] w_mag1, w_mag2, w_fast_val;
  logic             w_div0, w_ovf, w_fast;

  always_comb begin
    // Divides: DIV/REM signed, DIVU/REMU unsigned. Multiplies: only MULHU is
    // unsigned on in1, and only MUL/MULH treat in2 as signed.
    w_s1_signed = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    w_s2_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    w_neg1      = w_s1_signed & in1_i[WIDTH-1];
    w_neg2      = w_s2_signed & in2_i[WIDTH-1];
    w_mag1      = w_neg1 ? -in1_i : in1_i;
    w_mag2      = w_neg2 ? -in2_i : in2_i;
    // Remainder takes the dividend's sign; everything else the XOR.
    w_neg       = (op_i[2] & op_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

    w_div0      = op_i[2] & (in2_i == '0);
    w_ovf       = op_i[2] & ~op_i[0] & (in1_i == c_min) & (in2_i == c_ones);
    w_fast      = w_div0 | w_ovf;
    if (w_div0) w_fast_val = op_i[1] ? in1_i : c_ones;
    else        w_fast_val = op_i[1] ? '0    : in1_i;
  end

  // ---------------------------------------------------------------- datapath step
  logic [WIDTH:0]     w_add, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_step, w_mul_full;
  logic [WIDTH-1:0]   w_quot, w_rem, w_final;

  always_comb begin
    // Shift-add: add multiplicand to the high half when the multiplier LSB is
    // set, then shift the whole accumulator right including the carry.
    w_add   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Restoring divide: shift the next dividend bit into the partial remainder
    // and keep the difference only if it did not borrow.
    w_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, opb_q};

    if (op_q[2])
      w_step = {(w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                acc_q[WIDTH-2:0], ~w_diff[WIDTH]};
    else
      w_step = {w_add, acc_q[WIDTH-1:1]};

    w_mul_full = neg_q ? -w_step : w_step;
    w_quot     = w_step[WIDTH-1:0];
    w_rem      = w_step[2*WIDTH-1:WIDTH];

    if (!op_q[2])
      w_final = (op_q[1:0] == 2'b00) ? w_mul_full[WIDTH-1:0]
                                     : w_mul_full[2*WIDTH-1:WIDTH];
    else if (!op_q[1])
      w_final = neg_q ? -w_quot : w_quot;
    else
      w_final = neg_q ? -w_rem : w_rem;
  end

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_CALC;
          op_d    = op_i;
          neg_d   = w_neg;
          fast_d  = w_fast;
          cnt_d   = CNT_W'(WIDTH);
          opb_d   = op_i[2] ? w_mag2 : w_mag1;
          // Fast-path operations park their answer in the low half.
          acc_d   = {{WIDTH{1'b0}},
                     (w_fast ? w_fast_val : (op_i[2] ? w_mag1 : w_mag2))};
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (fast_q) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = acc_q[WIDTH-1:0];
          zero_d   = (acc_q[WIDTH-1:0] == '0);
        end else begin
          acc_d = w_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d  = S_DONE;
            result_d = w_final;
            zero_d   = (w_final == '0);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign busy_o      = (state_q == S_CALC);
  assign done_o      = (state_q == S_DONE);
  assign result_o    = result_q;
  assign zero_flag_o = zero_q;

endmodule
`default_nettype wire
